// File: rtl/pipeline_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Holds the forward-select and FSM encodings and the forward priority helper.
package pipeline_pkg;

  localparam int REG_ADDR_W = 3;
  localparam int CNT_W      = 16;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } state_t;

  // The memory stage holds the younger result, so it beats writeback; x0 is never forwarded.
  function automatic fwd_sel_t fwd_select(input reg_addr_t rs,
                                          input reg_addr_t rd_m, input logic wr_m,
                                          input reg_addr_t rd_w, input logic wr_w);
    if (wr_m && (rd_m != '0) && (rd_m == rs)) return FWD_M;
    if (wr_w && (rd_w != '0) && (rd_w == rs)) return FWD_W;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_controller_if.sv
// Pipeline-side hazard bus: stage register addresses and qualifiers in,
// forward selects, stall/flush controls and status counters out.
interface hazard_controller_if;
  import pipeline_pkg::*;

  reg_addr_t        Rs1_D, Rs2_D;
  reg_addr_t        Rs1_E, Rs2_E, RD_E;
  logic             ResultSrcE;
  logic             PCSrcE;
  reg_addr_t        RD_M;
  logic             RegWriteM;
  reg_addr_t        RD_W;
  logic             RegWriteW;
  logic             mem_req_M;
  logic             mem_ready;

  logic [1:0]       ForwardA_E, ForwardB_E;
  logic             StallF, StallD, StallE, StallM;
  logic             FlushD, FlushE;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  modport master (
    output Rs1_D, Rs2_D, Rs1_E, Rs2_E, RD_E, ResultSrcE, PCSrcE,
           RD_M, RegWriteM, RD_W, RegWriteW, mem_req_M, mem_ready,
    input  ForwardA_E, ForwardB_E, StallF, StallD, StallE, StallM,
           FlushD, FlushE, mem_timeout, stall_cnt, flush_cnt
  );

  modport slave (
    input  Rs1_D, Rs2_D, Rs1_E, Rs2_E, RD_E, ResultSrcE, PCSrcE,
           RD_M, RegWriteM, RD_W, RegWriteW, mem_req_M, mem_ready,
    output ForwardA_E, ForwardB_E, StallF, StallD, StallE, StallM,
           FlushD, FlushE, mem_timeout, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (clr)
      cnt <= '0;
    else if (en && (cnt != {W{1'b1}}))
      cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/hazard_controller.sv
// Hazard unit: operand forwarding, load-use/branch/memory-wait stall and flush
// control, memory wait timeout and stall/flush performance counters.
module hazard_controller
  import pipeline_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255
) (
  input logic                clk,
  input logic                rst,
  hazard_controller_if.slave hz
);

  localparam logic [7:0] TIMEOUT_V = 8'(TIMEOUT_CYC);

  state_t     state;
  logic [7:0] wait_cnt;
  logic       mem_timeout_q;
  logic       wait_c;
  logic       load_use;
  logic       flush_inc;

  // The cycle mem_ready rises completes the access, so the pipeline advances in it.
  assign wait_c   = !hz.mem_ready && ((state == ST_MEM_WAIT) || hz.mem_req_M);
  assign load_use = hz.ResultSrcE && (hz.RD_E != '0) &&
                    ((hz.RD_E == hz.Rs1_D) || (hz.RD_E == hz.Rs2_D));

  assign hz.ForwardA_E = rst ? FWD_RF
                             : fwd_select(hz.Rs1_E, hz.RD_M, hz.RegWriteM, hz.RD_W, hz.RegWriteW);
  assign hz.ForwardB_E = rst ? FWD_RF
                             : fwd_select(hz.Rs2_E, hz.RD_M, hz.RegWriteM, hz.RD_W, hz.RegWriteW);

  // NOTE: every output gets a default first so no path through the block infers a latch.
  always_comb begin
    hz.StallF = 1'b0;
    hz.StallD = 1'b0;
    hz.StallE = 1'b0;
    hz.StallM = 1'b0;
    hz.FlushD = 1'b0;
    hz.FlushE = 1'b0;
    if (!rst) begin
      if (wait_c) begin
        hz.StallF = 1'b1;
        hz.StallD = 1'b1;
        hz.StallE = 1'b1;
        hz.StallM = 1'b1;
      end else begin
        // A taken branch squashes the load-use victim anyway, so fetch follows the branch.
        hz.StallF = load_use && !hz.PCSrcE;
        hz.StallD = load_use && !hz.PCSrcE;
        hz.FlushD = hz.PCSrcE;
        hz.FlushE = load_use || hz.PCSrcE;
      end
    end
  end

  assign flush_inc = !rst && !wait_c && hz.PCSrcE;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_RUN;
      wait_cnt      <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (hz.mem_req_M && !hz.mem_ready) begin
            state    <= ST_MEM_WAIT;
            wait_cnt <= '0;
          end
        end
        ST_MEM_WAIT: begin
          if (hz.mem_ready) begin
            state <= ST_RUN;
          end else begin
            if (wait_cnt != 8'hFF) wait_cnt <= wait_cnt + 8'd1;
            // Timeout is only flagged; the access may still complete later.
            if ((wait_cnt + 8'd1) >= TIMEOUT_V) mem_timeout_q <= 1'b1;
          end
        end
        default: state <= ST_RUN;
      endcase
    end
  end

  assign hz.mem_timeout = mem_timeout_q;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .clr (rst),
    .en  (hz.StallF),
    .cnt (hz.stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .clr (rst),
    .en  (flush_inc),
    .cnt (hz.flush_cnt)
  );

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller: a cycle-level reference model checked
// every cycle, plus hand-computed expectations at the scenario checkpoints.
module tb_hazard_controller;

  localparam int TO = 5;

  typedef struct packed {
    bit sf, sd, se, sm, fd, fe;
  } ctrl_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  bit   chk_en = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model state
  bit m_in_wait = 1'b0;
  int m_wait    = 0;
  bit m_to      = 1'b0;
  int m_stall   = 0;
  int m_flush   = 0;

  ctrl_t cmp_e, mdl_e;

  hazard_controller_if hz();

  hazard_controller #(.TIMEOUT_CYC(TO)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory access still outstanding this cycle.
  function automatic bit waiting();
    return (m_in_wait || hz.mem_req_M) && !hz.mem_ready;
  endfunction

  function automatic ctrl_t exp_ctrl();
    ctrl_t c;
    bit lu, br;
    c = '0;
    if (rst) return c;
    if (waiting()) begin
      c.sf = 1; c.sd = 1; c.se = 1; c.sm = 1;
      return c;
    end
    lu = hz.ResultSrcE && (hz.RD_E != 0) && ((hz.RD_E == hz.Rs1_D) || (hz.RD_E == hz.Rs2_D));
    br = hz.PCSrcE;
    c.fd = br;
    c.fe = lu || br;
    c.sf = lu && !br;
    c.sd = lu && !br;
    return c;
  endfunction

  function automatic int exp_fwd(input logic [2:0] rs);
    int sel;
    sel = 0;
    if (rst || rs == 0) return 0;
    if (hz.RegWriteW && hz.RD_W == rs) sel = 1;
    if (hz.RegWriteM && hz.RD_M == rs) sel = 2;
    return sel;
  endfunction

  // Model state advance
  always @(posedge clk) begin
    mdl_e = exp_ctrl();
    if (rst) begin
      m_in_wait <= 0; m_wait <= 0; m_to <= 0; m_stall <= 0; m_flush <= 0;
    end else begin
      if (mdl_e.sf && m_stall < 65535) m_stall <= m_stall + 1;
      if (hz.PCSrcE && !waiting() && m_flush < 65535) m_flush <= m_flush + 1;
      if (m_in_wait) begin
        if (hz.mem_ready) m_in_wait <= 0;
        else begin
          m_wait <= m_wait + 1;
          if (m_wait + 1 >= TO) m_to <= 1;
        end
      end else if (hz.mem_req_M && !hz.mem_ready) begin
        m_in_wait <= 1;
        m_wait    <= 0;
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      cmp_e = exp_ctrl();
      check("StallF", hz.StallF, cmp_e.sf);
      check("StallD", hz.StallD, cmp_e.sd);
      check("StallE", hz.StallE, cmp_e.se);
      check("StallM", hz.StallM, cmp_e.sm);
      check("FlushD", hz.FlushD, cmp_e.fd);
      check("FlushE", hz.FlushE, cmp_e.fe);
      check("ForwardA_E", hz.ForwardA_E, exp_fwd(hz.Rs1_E));
      check("ForwardB_E", hz.ForwardB_E, exp_fwd(hz.Rs2_E));
      check("mem_timeout", hz.mem_timeout, m_to);
      check("stall_cnt", hz.stall_cnt, m_stall);
      check("flush_cnt", hz.flush_cnt, m_flush);
    end
  end

  task automatic idle();
    hz.Rs1_D = 0; hz.Rs2_D = 0; hz.Rs1_E = 0; hz.Rs2_E = 0; hz.RD_E = 0;
    hz.ResultSrcE = 0; hz.PCSrcE = 0; hz.RD_M = 0; hz.RegWriteM = 0;
    hz.RD_W = 0; hz.RegWriteW = 0; hz.mem_req_M = 0; hz.mem_ready = 0;
  endtask

  task automatic obs();
    @(negedge clk);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic cycle();
    obs();
    adv();
  endtask

  initial begin
    idle();
    rst = 1;
    cycle();
    chk_en = 1;

    // Reset masks every hazard source
    hz.PCSrcE = 1; hz.ResultSrcE = 1; hz.RD_E = 2; hz.Rs2_D = 2;
    hz.RegWriteM = 1; hz.RD_M = 3; hz.Rs1_E = 3; hz.mem_req_M = 1;
    obs();
    check("rst StallF", hz.StallF, 0);
    check("rst FlushD", hz.FlushD, 0);
    check("rst FlushE", hz.FlushE, 0);
    check("rst ForwardA_E", hz.ForwardA_E, 0);
    adv();

    rst = 0; idle();
    obs();
    check("post-rst stall_cnt", hz.stall_cnt, 0);
    check("post-rst mem_timeout", hz.mem_timeout, 0);
    adv();

    // Forwarding priority
    hz.RD_M = 3; hz.RD_W = 3; hz.Rs1_E = 3; hz.RegWriteM = 1; hz.RegWriteW = 1;
    obs(); check("fwdA M over W", hz.ForwardA_E, 2'b10); adv();
    hz.RegWriteM = 0;
    obs(); check("fwdA W", hz.ForwardA_E, 2'b01); adv();
    hz.RD_W = 0;
    obs(); check("fwdA none", hz.ForwardA_E, 2'b00); adv();
    idle(); hz.Rs2_E = 5; hz.RD_M = 5; hz.RD_W = 5; hz.RegWriteM = 1; hz.RegWriteW = 1;
    obs(); check("fwdB M", hz.ForwardB_E, 2'b10); adv();
    hz.Rs2_E = 0; hz.RD_M = 0; hz.RD_W = 0;
    obs(); check("fwdB x0", hz.ForwardB_E, 2'b00); adv();

    // Load-use
    idle(); hz.ResultSrcE = 1; hz.RD_E = 2; hz.Rs2_D = 2;
    obs();
    check("lu StallF", hz.StallF, 1);
    check("lu StallD", hz.StallD, 1);
    check("lu FlushE", hz.FlushE, 1);
    check("lu StallE", hz.StallE, 0);
    check("lu stall_cnt before", hz.stall_cnt, 0);
    adv();
    idle();
    obs();
    check("lu StallF cleared", hz.StallF, 0);
    check("lu stall_cnt after", hz.stall_cnt, 1);
    adv();
    hz.ResultSrcE = 1;
    obs(); check("lu x0 StallF", hz.StallF, 0); check("lu x0 FlushE", hz.FlushE, 0); adv();

    // Branch in RUN
    idle(); hz.PCSrcE = 1;
    obs(); check("br FlushD", hz.FlushD, 1); check("br FlushE", hz.FlushE, 1); adv();
    idle();
    obs(); check("br flush_cnt", hz.flush_cnt, 1); adv();

    // Load-use and branch together
    hz.PCSrcE = 1; hz.ResultSrcE = 1; hz.RD_E = 4; hz.Rs1_D = 4;
    obs();
    check("lu+br FlushD", hz.FlushD, 1);
    check("lu+br FlushE", hz.FlushE, 1);
    check("lu+br StallF", hz.StallF, 0);
    check("lu+br StallD", hz.StallD, 0);
    adv();
    idle();
    obs(); check("lu+br flush_cnt", hz.flush_cnt, 2); check("lu+br stall_cnt", hz.stall_cnt, 1); adv();

    // Memory wait for 4 cycles, branch ignored while waiting
    for (int i = 0; i < 4; i++) begin
      idle(); hz.mem_req_M = 1; hz.PCSrcE = (i == 2);
      obs();
      check("mw StallM", hz.StallM, 1);
      check("mw StallF", hz.StallF, 1);
      check("mw FlushD", hz.FlushD, 0);
      check("mw FlushE", hz.FlushE, 0);
      adv();
    end
    idle(); hz.mem_req_M = 1; hz.mem_ready = 1;
    obs(); check("mw ready StallF", hz.StallF, 0); check("mw ready StallE", hz.StallE, 0); adv();
    idle();
    obs(); check("mw stall_cnt", hz.stall_cnt, 5); check("mw flush_cnt", hz.flush_cnt, 2); adv();

    // Timeout after 5 wait cycles, sticky until reset
    rst = 1; cycle(); rst = 0;
    idle(); hz.mem_req_M = 1;
    cycle();
    for (int i = 1; i <= 5; i++) begin
      obs(); check("to pending", hz.mem_timeout, 0); adv();
    end
    hz.mem_ready = 1;
    obs(); check("to set", hz.mem_timeout, 1); check("to ready StallF", hz.StallF, 0); adv();
    idle();
    obs(); check("to sticky", hz.mem_timeout, 1); check("to RUN StallF", hz.StallF, 0); adv();

    // Reset while in MEM_WAIT
    hz.mem_req_M = 1; cycle();
    idle(); rst = 1; cycle(); rst = 0;
    obs(); check("rst to clear", hz.mem_timeout, 0); check("rst back to RUN", hz.StallF, 0); adv();

    // Counter saturation
    hz.mem_req_M = 1;
    for (int i = 0; i < 70000; i++) cycle();
    obs(); check("sat stall_cnt", hz.stall_cnt, 16'hFFFF); adv();
    hz.mem_ready = 1; cycle();
    idle();
    obs(); check("sat hold", hz.stall_cnt, 16'hFFFF); adv();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hazard_controller.md
HAZARD_CONTROLLER -- requirements
Module: hazard_controller

Interface
REQ-001 Parameter TIMEOUT_CYC, default 255: memory-wait cycles before mem_timeout is set.
REQ-002 Ports (name, direction, width, meaning):
- clk, in, 1: sole clock, all state updates on rising edge.
- rst, in, 1: synchronous, active-high reset.
- Rs1_D, Rs2_D, in, 3: decode-stage source registers.
- Rs1_E, Rs2_E, RD_E, in, 3: execute-stage sources and destination.
- ResultSrcE, in, 1: execute-stage instruction is a load.
- PCSrcE, in, 1: branch or jump taken in execute.
- RD_M, in, 3: memory-stage destination.
- RegWriteM, in, 1: memory-stage register write.
- RD_W, in, 3: writeback-stage destination.
- RegWriteW, in, 1: writeback-stage register write.
- mem_req_M, in, 1: memory stage is accessing data memory.
- mem_ready, in, 1: data memory completes the access this cycle.
- ForwardA_E, ForwardB_E, out, 2: source-A and source-B forward selects.
- StallF, StallD, StallE, StallM, out, 1: hold the corresponding stage register.
- FlushD, FlushE, out, 1: clear the corresponding stage register.
- mem_timeout, out, 1: sticky wait-timeout error.
- stall_cnt, flush_cnt, out, 16: performance counters.

Function
REQ-003 Forward select encoding: 00 = register file, 01 = ResultW, 10 = ALU_ResultM.
REQ-004 ForwardA_E is combinational:
- 10 if RegWriteM, RD_M!=0 and RD_M==Rs1_E;
- else 01 if RegWriteW, RD_W!=0 and RD_W==Rs1_E;
- else 00.
REQ-005 ForwardB_E uses the same rule with Rs2_E; the M stage beats the W stage when both match.
REQ-006 Register 0 shall never be forwarded and shall never cause a stall.
REQ-007 FSM states are RUN and MEM_WAIT; reset state is RUN.
REQ-008 RUN to MEM_WAIT when mem_req_M=1 and mem_ready=0; MEM_WAIT to RUN on the first cycle with mem_ready=1.
REQ-009 Wait condition: state==MEM_WAIT, or (state==RUN, mem_req_M=1 and mem_ready=0).
- StallF, StallD, StallE and StallM shall be 1 in the same cycle.
- FlushD and FlushE shall be 0.
- Load-use and PCSrcE shall be ignored.
REQ-010 Load-use condition, outside the wait condition: ResultSrcE=1, RD_E!=0, and RD_E==Rs1_D or RD_E==Rs2_D.
- StallF=1, StallD=1, FlushE=1 for that cycle.
- StallE=0, StallM=0.
REQ-011 Branch condition: PCSrcE=1 outside the wait condition gives FlushD=1 and FlushE=1.
REQ-012 Load-use and branch in the same cycle: FlushE=1, FlushD=1, StallF=0, StallD=0; the branch wins the fetch path.
REQ-013 With no condition active, all stall and flush outputs shall be 0.
REQ-014 An 8-bit wait counter clears on entry to MEM_WAIT and increments each MEM_WAIT cycle.
REQ-015 When the wait counter reaches TIMEOUT_CYC, mem_timeout shall go to 1 and hold until rst; the FSM keeps waiting.
REQ-016 stall_cnt shall increment on every cycle with StallF=1 and saturate at 16'hFFFF.
REQ-017 flush_cnt shall increment on every cycle where PCSrcE causes a flush and saturate at 16'hFFFF.
REQ-018 Stall and flush outputs are combinational from state and inputs, with zero-cycle latency.

Reset
REQ-019 rst=1 at a clock edge sets: state=RUN, wait counter=0, mem_timeout=0, stall_cnt=0, flush_cnt=0.
REQ-020 While rst=1, all stall and flush outputs shall be 0 and forward selects shall be 00, regardless of inputs.
REQ-021 Reset asserted during MEM_WAIT shall return the FSM to RUN on that edge without waiting for mem_ready.

Structure
REQ-022 Shared package pipeline_pkg shall hold:
- forward encodings FWD_RF, FWD_W, FWD_M;
- state encodings ST_RUN, ST_MEM_WAIT;
- REG_ADDR_W=3 and CNT_W=16.
REQ-023 One sub-module, sat_counter (CNT_W-bit, increment enable, synchronous clear), shall be instantiated twice.

Verification
REQ-024 Forwarding priority: RD_M=RD_W=Rs1_E=3, both RegWrite=1 -> ForwardA_E=10; then RegWriteM=0 -> 01; then RD_W=0 -> 00.
REQ-025 Load-use: ResultSrcE=1, RD_E=2, Rs2_D=2 -> StallF=1, StallD=1, FlushE=1 for one cycle; stall_cnt goes 0 to 1.
REQ-026 Memory wait: mem_req_M=1, mem_ready=0 for 4 cycles, then 1 -> all four stalls high for 4 cycles, low in the ready cycle, stall_cnt=4.
REQ-027 Wait versus branch: PCSrcE=1 during MEM_WAIT -> FlushD=0, FlushE=0, flush_cnt unchanged; PCSrcE=1 in RUN -> both flushes 1, flush_cnt increments.
REQ-028 Timeout: TIMEOUT_CYC=5, mem_ready held 0 -> mem_timeout=1 after 5 MEM_WAIT cycles and stays 1 after mem_ready; then rst=1 -> mem_timeout=0, state=RUN.
REQ-029 Saturation: drive StallF continuously for 70000 cycles -> stall_cnt holds at 16'hFFFF with no wrap to 0.
